// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: returns mem[req_pc] LATENCY cycles after IDLE capture; one fetch per LATENCY+1 cycles.
// Backpressure: mem_busy stalls IF until DONE; hold parks DONE; branch_cancel aborts to IDLE.
module inst_mem_responder #(
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 3,
   parameter logic [31:0] NOP     = 32'hE1A00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] req_pc,
   input  logic        branch_cancel,
   input  logic        hold,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic [31:0] instruction,
   output logic        inst_valid,
   output logic        mem_busy
);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [IW-1:0]   addr_q, addr_d, rd_idx, req_idx, load_idx;
   logic [31:0]     data_q;
   logic            data_ld;
   logic [31:0]     mem [DEPTH];
   logic            unused_bits;

   assign req_idx     = req_pc[IW+1:2];
   assign load_idx    = load_addr[IW+1:2];
   assign unused_bits = ^{req_pc[31:IW+2], req_pc[1:0], load_addr[31:IW+2], load_addr[1:0]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rd_idx      = addr_q;
      data_ld     = 1'b0;
      instruction = NOP;
      inst_valid  = 1'b0;
      mem_busy    = 1'b1;
      case (state_q)
         IDLE: begin
            addr_d = req_idx;
            cnt_d  = 4'(LATENCY - 1);
            // Single-cycle build reads straight from the incoming PC.
            rd_idx = req_idx;
            if (LATENCY == 1) begin
               state_d = DONE;
               data_ld = 1'b1;
            end else begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
               data_ld = 1'b1;
            end
         end
         DONE: begin
            instruction = data_q;
            inst_valid  = 1'b1;
            mem_busy    = 1'b0;
            if (!hold) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Releasing the stall lets the PC register take the branch target this cycle.
      if (branch_cancel) begin
         state_d     = IDLE;
         cnt_d       = cnt_q;
         addr_d      = addr_q;
         data_ld     = 1'b0;
         instruction = NOP;
         inst_valid  = 1'b0;
         mem_busy    = 1'b0;
      end
      if (rst) begin
         instruction = NOP;
         inst_valid  = 1'b0;
         mem_busy    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         data_q  <= NOP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         if (data_ld) data_q <= mem[rd_idx];
      end
   end

   // No reset: contents survive reset and loads are taken in every state.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_idx] <= load_data;
   end
endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder side of the instruction-fetch interface: accepts the fetch PC from the IF stage and returns the addressed instruction word after a configurable multi-cycle latency.
- Stalls the fetch stage while an access is in progress by driving mem_busy, which is ORed into the IF freeze.
- Aborts an in-flight access when a branch is taken.
- Provides a load port so a testbench or bootloader can fill the word array.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words; power of two.
- LATENCY, 3, cycles from address capture to valid data; legal range 1..15.
- NOP, 32'hE1A00000, word presented whenever no valid instruction is available (mov r0,r0).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_pc  input  32  fetch address from IF stage PC register
- branch_cancel  input  1  Branch_taken from EX; aborts current access
- hold  input  1  external freeze from hazard unit; IF stage not advancing
- load_en  input  1  write enable for load port
- load_addr  input  32  byte address for load write
- load_data  input  32  word to write
- instruction  output  32  fetched word; NOP when inst_valid=0
- inst_valid  output  1  instruction corresponds to the last captured req_pc
- mem_busy  output  1  stall request to IF stage, ORed into freeze

Behaviour:
- Word index is req_pc[log2(DEPTH)+1:2]. req_pc[1:0] and bits above the index are ignored, so addresses wrap modulo DEPTH*4. The load port uses the same mapping on load_addr.
- FSM states: IDLE, ACCESS, DONE. Counter cnt is 4 bits wide.
- IDLE:
  - Captures req_pc into addr_q and sets cnt to LATENCY-1.
  - Next state is ACCESS, or DONE if LATENCY==1.
  - mem_busy=1, inst_valid=0.
- ACCESS:
  - cnt decrements each cycle. When cnt==1 and the cycle ends, go to DONE.
  - data_q is loaded at that edge with mem[addr_q] as read from the array.
  - mem_busy=1, inst_valid=0.
- DONE:
  - instruction=data_q, inst_valid=1, mem_busy=0. These are combinational from the state, so the IF register latches in this cycle.
  - hold=1: remain in DONE; data and outputs stable.
  - hold=0: go to IDLE; the new req_pc is captured there.
- Throughput: one instruction every LATENCY+1 cycles. inst_valid rises exactly LATENCY cycles after the IDLE capture cycle.
- branch_cancel=1 in any state:
  - mem_busy forced 0 and inst_valid forced 0 in that cycle, so the PC register accepts BranchAddr.
  - Next state is IDLE and data_q is not updated.
  - This takes priority over hold and over the DONE hold/advance decision.
- hold has no effect in IDLE or ACCESS.
- Load port: when load_en=1, mem[index(load_addr)] is written at the clock edge. A write at the same edge as the DONE-entry read returns the old data (read-before-write).
- Loads are accepted in every state, including during reset.
- Reset:
  - state=IDLE, cnt=0, data_q=NOP, addr_q=0.
  - Outputs during and after reset: instruction=NOP, inst_valid=0, mem_busy=1.
  - Memory contents are not cleared.
  - Reset mid-access discards the access. rst has priority over branch_cancel.
- instruction equals NOP whenever inst_valid=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with state in ACCESS -> IDLE, instruction=32'hE1A00000, inst_valid=0, mem_busy=1; a preloaded mem[0] is unchanged.
- Sequential fetch, LATENCY=3:
  - Preload mem[0]=32'hE3A00001 and mem[1]=32'hE3A01002.
  - Release reset with req_pc=0 (cycle 0 = IDLE) -> cycle 3: inst_valid=1, instruction=32'hE3A00001, mem_busy=0 for that one cycle only.
  - Then req_pc=4 -> cycle 7: instruction=32'hE3A01002.
- Hold: hold=1 for 3 cycles while in DONE -> instruction stays 32'hE3A00001, inst_valid=1, mem_busy=0, req_pc not recaptured. The next fetch starts the cycle after hold falls.
- Branch cancel:
  - Assert branch_cancel in the second ACCESS cycle of a fetch at 0x8, with req_pc becoming 0x40 -> that cycle has mem_busy=0, inst_valid=0.
  - The next cycle is IDLE capturing 0x40, and mem[16] is returned 3 cycles later. The word at 0x8 never appears.
- Wrap and collision:
  - DEPTH=1024, req_pc=0x1006 -> returns mem[1].
  - A load_en write of mem[1]=32'hDEADBEEF on the DONE-entry edge still returns the old word. The next fetch of 0x4 returns 32'hDEADBEEF.
- LATENCY=1 build: back-to-back fetches -> inst_valid high every second cycle, alternating with IDLE; mem_busy is the complement of inst_valid.
